wb_write_arbiter: RTL
=====================

Name: wb_write_arbiter

Overview:
- Owns the single write agent of the register file (write address, write data, write enable).
- Merges two write sources:
  - the in-order pipeline WB stage, which has fixed priority and never stalls;
  - a multi-cycle execution unit (mul/div/load miss), which uses a valid/ready handshake into a small in-order queue.
- Publishes pending-write flags for decode hazard checks.
- Raises a stall request when queued writes starve.

Parameters:
- DEPTH, 4, queue entries for multi-cycle results; must be a power of 2 and at least 2.
- STARVE_LIMIT, 8, consecutive blocked cycles with a non-empty queue before stall_req asserts; range 1..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clrn  in  1  synchronous active-low reset.
- pipe_wen  in  1  WB stage write enable.
- pipe_wn  in  5  WB stage destination register.
- pipe_data  in  32  WB stage result.
- mc_valid  in  1  multi-cycle result valid.
- mc_wn  in  5  multi-cycle destination register.
- mc_data  in  32  multi-cycle result.
- mc_ready  out  1  queue can accept a result this cycle.
- rq_a  in  5  decode query register A.
- rq_b  in  5  decode query register B.
- pending_a  out  1  rq_a has a queued, not yet written result.
- pending_b  out  1  rq_b has a queued, not yet written result.
- w_en  out  1  write enable to the register file.
- w_number  out  5  write register address to the register file.
- w_data  out  32  write data to the register file.
- q_count  out  $clog2(DEPTH+1)  current queue occupancy.
- stall_req  out  1  request that the pipeline bubble WB.

Behaviour:
- Reset (clrn=0 at a rising edge):
  - queue emptied: pointers=0, q_count=0; starve counter=0; stall_req=0.
  - Queued entries are discarded without being written, including in-flight ones.
  - While clrn=0, w_en=0, mc_ready=0, pending_a=pending_b=0, and w_number/w_data=0.
- Port usage:
  - pipe_busy = pipe_wen && pipe_wn!=0.
  - A pipeline write to r0 does not occupy the port.
- Output mux (combinational, same cycle):
  - If pipe_busy: w_en=1, w_number=pipe_wn, w_data=pipe_data.
  - Else if q_count>0: w_en=1, w_number/w_data come from the queue head, and the head pops at the clock edge.
  - Else: w_en=0, w_number=0, w_data=0.
- Handshake:
  - mc_ready = (q_count<DEPTH). It does not depend on a same-cycle pop; there is no ready-through when full.
  - Transfer happens when mc_valid && mc_ready.
  - If mc_wn!=0, the entry is pushed at the tail.
  - If mc_wn==0, the transfer completes but nothing is enqueued.
  - mc_data/mc_wn are sampled only on a transfer.
- Latency:
  - An accepted result can appear on the write port no earlier than the next cycle; there is no bypass from mc_* to w_*.
  - Queue order is strict FIFO.
- Simultaneous push and pop: allowed when 0<q_count<DEPTH; q_count is unchanged.
- Pointers are log2(DEPTH) bits and wrap naturally.
- Pending flags (combinational):
  - pending_x = (rq_x!=0) and rq_x matches the register number of any occupied queue entry.
  - An entry popping this cycle still counts as pending in that cycle.
  - WAW/RAW ordering between the pipeline and the queue is decode's responsibility, using pending_x. This block never reorders or merges writes.
- Starvation counter:
  - Increments each cycle where q_count>0 && pipe_busy, saturating at STARVE_LIMIT.
  - Clears on any pop or when q_count==0.
  - stall_req=1 is registered and asserts the cycle after the counter reaches STARVE_LIMIT.
  - stall_req deasserts the cycle after the next pop.
  - The pipeline answers stall_req by driving pipe_wen=0. If the pipeline does not comply, the counter stays saturated and stall_req stays high.
- The register file must see a stable w_en/w_number/w_data in each cycle; all outputs are glitch-free functions of registered state and the pipe_*/rq_* inputs.

Test Plan:
- Reset mid-operation: fill 3 entries, pull clrn=0 for 1 cycle → q_count=0, w_en=0, mc_ready=0 during reset; no queued write ever reaches w_*.
- Pipeline priority: hold pipe_wen=1, pipe_wn=5, pipe_data=0xAAAA_0001; push mc_wn=7, mc_data=0x1234 → w_number=5 while pipe is busy. When pipe_wen drops, the next cycle drives w_en=1, w_number=7, w_data=0x1234, then q_count=0.
- Full queue: push 4 entries (r1..r4) with pipe busy → q_count=4, mc_ready=0, a 5th mc_valid is held. Drop pipe_wen → writes r1,r2,r3,r4 on consecutive cycles; mc_ready=1 the cycle after the first pop.
- r0 handling: mc_valid with mc_wn=0 → accepted with q_count unchanged. pipe_wen=1 with pipe_wn=0 and queue head r9 → r9 is written that cycle.
- Pending flags: queue holds r3 and r12; rq_a=12, rq_b=0 → pending_a=1, pending_b=0. After r12 is written, pending_a=0 on the following cycle.
- Starvation (STARVE_LIMIT=8): 1 entry queued, pipe_busy for 8 cycles → stall_req=1 on cycle 9. Drop pipe_wen → pop occurs, and stall_req=0 the following cycle.

Source files
------------

// File: rtl/wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module : wb_write_arbiter
// Merges fixed-priority pipeline WB writes with an in-order queue of
// multi-cycle results onto the single register-file write port.
// Rev    : 1.0  initial release
// ============================================================================
module wb_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       clrn,
  input  logic                       pipe_wen,
  input  logic [4:0]                 pipe_wn,
  input  logic [31:0]                pipe_data,
  input  logic                       mc_valid,
  input  logic [4:0]                 mc_wn,
  input  logic [31:0]                mc_data,
  output logic                       mc_ready,
  input  logic [4:0]                 rq_a,
  input  logic [4:0]                 rq_b,
  output logic                       pending_a,
  output logic                       pending_b,
  output logic                       w_en,
  output logic [4:0]                 w_number,
  output logic [31:0]                w_data,
  output logic [$clog2(DEPTH+1)-1:0] q_count,
  output logic                       stall_req
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [SW-1:0] C_LIMIT = SW'(STARVE_LIMIT);

  logic [4:0]    wn_q   [DEPTH];
  logic [4:0]    wn_d   [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          stall_q, stall_d;

  logic pipe_busy;
  logic q_nonempty;
  logic pop;
  logic push;

  always_comb begin
    pipe_busy  = pipe_wen && (pipe_wn != 5'd0);
    q_nonempty = (count_q != '0);
    // Ready looks only at registered occupancy, so a full queue never accepts even while popping.
    mc_ready   = clrn && (count_q < C_DEPTH);
    pop        = clrn && q_nonempty && !pipe_busy;
    push       = mc_valid && mc_ready && (mc_wn != 5'd0);

    wn_d   = wn_q;
    data_d = data_q;
    if (push) begin
      wn_d[wr_ptr_q]   = mc_wn;
      data_d[wr_ptr_q] = mc_data;
    end

    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);

    if (pop || !q_nonempty) begin
      starve_d = '0;
    end else if (pipe_busy && (starve_q != C_LIMIT)) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end
    stall_d = (starve_d == C_LIMIT);
  end

  always_comb begin
    w_en     = 1'b0;
    w_number = 5'd0;
    w_data   = 32'd0;
    if (clrn) begin
      if (pipe_busy) begin
        w_en     = 1'b1;
        w_number = pipe_wn;
        w_data   = pipe_data;
      end else if (q_nonempty) begin
        w_en     = 1'b1;
        w_number = wn_q[rd_ptr_q];
        w_data   = data_q[rd_ptr_q];
      end
    end
  end

  // Only the count_q entries starting at the head are live; the head still counts while it pops.
  always_comb begin
    pending_a = 1'b0;
    pending_b = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count_q) begin
        if (wn_q[rd_ptr_q + PW'(k)] == rq_a) pending_a = 1'b1;
        if (wn_q[rd_ptr_q + PW'(k)] == rq_b) pending_b = 1'b1;
      end
    end
    if (!clrn || (rq_a == 5'd0)) pending_a = 1'b0;
    if (!clrn || (rq_b == 5'd0)) pending_b = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  always_ff @(posedge clk) begin
    wn_q   <= wn_d;
    data_q <= data_d;
  end

  assign q_count   = count_q;
  assign stall_req = stall_q;

endmodule
`default_nettype wire
